m92_sound_latch: RTL and testbench

Command/reply mailbox between the main V30 I/O bus and the sound CPU.
- Main CPU byte writes to I/O port 0x00 are queued as sound commands; the sound CPU is interrupted until it drains them.
- Sound CPU replies are held in a 16-bit latch that the main CPU reads at ports 0x08/0x09 (soundlatch2). A pending reply raises a level request that feeds a spare `m92_pic` `intp` input.

---
 rtl/m92_sound_latch.sv | 117 +++++++++++
 tb/tb_m92_sound_latch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m92_sound_latch.sv
// Main-to-sound command queue plus sound-to-main 16-bit reply latch.
// Commands arrive on main I/O port 0x00; replies are read back at ports 0x08/0x09.
module m92_sound_latch #(
  parameter int unsigned DEPTH = 1
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        main_io_wr,
  input  logic        main_io_rd,
  input  logic [7:0]  main_io_addr,
  input  logic [7:0]  main_io_din,
  output logic [7:0]  main_io_dout,
  output logic        main_irq,
  input  logic        snd_rd,
  output logic [7:0]  snd_cmd,
  output logic        snd_irq,
  input  logic        snd_reply_wr,
  input  logic [15:0] snd_reply_data,
  output logic [7:0]  snd_status
);

  localparam logic [3:0] DepthCnt = 4'(DEPTH);
  localparam logic [2:0] PtrLast  = 3'(DEPTH - 1);

  logic [7:0]  queue_q [8];
  logic [2:0]  rd_ptr_q, wr_ptr_q;
  logic [3:0]  count_q, count_d;
  logic        overflow_q;
  logic [7:0]  snd_cmd_q;
  logic        snd_irq_q;
  logic [15:0] reply_q;
  logic        pending_q;

  logic cmd_push, ovf_clr, reply_clr, do_pop, do_push, push_drop;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == PtrLast) ? 3'd0 : p + 3'd1;
  endfunction

  always_comb begin
    cmd_push  = main_io_wr && (main_io_addr == 8'h00);
    ovf_clr   = main_io_wr && (main_io_addr == 8'h0A);
    reply_clr = main_io_rd && (main_io_addr == 8'h09);
    do_pop    = snd_rd && (count_q != 4'd0);
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    do_push   = cmd_push && ((count_q != DepthCnt) || do_pop);
    push_drop = cmd_push && !do_push;
  end

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 4'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) queue_q[i] <= 8'h00;
      rd_ptr_q   <= 3'd0;
      wr_ptr_q   <= 3'd0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
      snd_cmd_q  <= 8'h00;
      snd_irq_q  <= 1'b0;
    end else begin
      if (do_push) begin
        queue_q[wr_ptr_q] <= main_io_din;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (snd_rd) begin
        snd_cmd_q <= do_pop ? queue_q[rd_ptr_q] : 8'hFF;
      end
      if (push_drop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
      count_q   <= count_d;
      snd_irq_q <= (count_d != 4'd0);
    end
  end

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      reply_q   <= 16'hFFFF;
      pending_q <= 1'b0;
    end else if (snd_reply_wr) begin
      // A new reply beats a simultaneous clearing read.
      reply_q   <= snd_reply_data;
      pending_q <= 1'b1;
    end else if (reply_clr) begin
      pending_q <= 1'b0;
    end
  end

  always_comb begin
    main_io_dout = 8'hFF;
    case (main_io_addr)
      8'h08:   main_io_dout = reply_q[7:0];
      8'h09:   main_io_dout = reply_q[15:8];
      8'h0A:   main_io_dout = {pending_q, overflow_q, 2'b00, count_q};
      default: main_io_dout = 8'hFF;
    endcase
  end

  assign main_irq   = pending_q;
  assign snd_cmd    = snd_cmd_q;
  assign snd_irq    = snd_irq_q;
  assign snd_status = {overflow_q, 3'b000, count_q};

endmodule

// File: tb/tb_m92_sound_latch.sv
// Drives DEPTH=1 and DEPTH=4 latches with shared stimulus and compares both
// against a queue-based model of the mailbox.
module tb_m92_sound_latch;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        main_io_wr, main_io_rd, snd_rd, snd_reply_wr;
  logic [7:0]  main_io_addr, main_io_din;
  logic [15:0] snd_reply_data;
  logic [7:0]  dout1, dout4, cmd1_o, cmd4_o, status1, status4;
  logic        mirq1, mirq4, sirq1, sirq4;

  int n_checks = 0;
  int n_fail   = 0;

  byte_q_t     q1, q4;
  logic        ov1, ov4;
  logic [7:0]  cmd1, cmd4;
  logic [15:0] m_reply;
  logic        m_pending;

  always #5 clk = ~clk;

  m92_sound_latch #(.DEPTH(1)) u_dut1 (
    .CLK_32M(clk), .reset(reset),
    .main_io_wr(main_io_wr), .main_io_rd(main_io_rd),
    .main_io_addr(main_io_addr), .main_io_din(main_io_din),
    .main_io_dout(dout1), .main_irq(mirq1),
    .snd_rd(snd_rd), .snd_cmd(cmd1_o), .snd_irq(sirq1),
    .snd_reply_wr(snd_reply_wr), .snd_reply_data(snd_reply_data),
    .snd_status(status1)
  );

  m92_sound_latch #(.DEPTH(4)) u_dut4 (
    .CLK_32M(clk), .reset(reset),
    .main_io_wr(main_io_wr), .main_io_rd(main_io_rd),
    .main_io_addr(main_io_addr), .main_io_din(main_io_din),
    .main_io_dout(dout4), .main_irq(mirq4),
    .snd_rd(snd_rd), .snd_cmd(cmd4_o), .snd_irq(sirq4),
    .snd_reply_wr(snd_reply_wr), .snd_reply_data(snd_reply_data),
    .snd_status(status4)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q4.delete();
    ov1 = 1'b0;
    ov4 = 1'b0;
    cmd1 = 8'h00;
    cmd4 = 8'h00;
    m_reply = 16'hFFFF;
    m_pending = 1'b0;
  endtask

  // Pop is resolved before push, so a full queue accepts a simultaneous push
  // and an empty queue reports 0xFF while still taking the push.
  task automatic step_q(input int d, input logic push, input logic pop, input logic clr,
                        input logic [7:0] din, inout byte_q_t q, inout logic ov,
                        inout logic [7:0] cmd);
    if (pop) begin
      if (q.size() > 0) cmd = q.pop_front();
      else cmd = 8'hFF;
    end
    if (push) begin
      if (q.size() < d) q.push_back(din);
      else ov = 1'b1;
    end
    if (clr) ov = 1'b0;
  endtask

  function automatic logic [7:0] exp_dout(input logic [7:0] a, input int cnt, input logic ov);
    case (a)
      8'h08:   return m_reply[7:0];
      8'h09:   return m_reply[15:8];
      8'h0A:   return {m_pending, ov, 2'b00, 4'(cnt)};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check_outputs();
    check("snd_cmd1", {8'h00, cmd1_o}, {8'h00, cmd1});
    check("snd_cmd4", {8'h00, cmd4_o}, {8'h00, cmd4});
    check("snd_irq1", {15'd0, sirq1}, {15'd0, q1.size() != 0});
    check("snd_irq4", {15'd0, sirq4}, {15'd0, q4.size() != 0});
    check("status1", {8'h00, status1}, {8'h00, ov1, 3'b000, 4'(q1.size())});
    check("status4", {8'h00, status4}, {8'h00, ov4, 3'b000, 4'(q4.size())});
    check("main_irq1", {15'd0, mirq1}, {15'd0, m_pending});
    check("main_irq4", {15'd0, mirq4}, {15'd0, m_pending});
  endtask

  // One bus cycle: entered just after a rising edge, returns 1 ns after the next one.
  task automatic access(input logic wr, input logic mrd, input logic [7:0] addr,
                        input logic [7:0] din, input logic srd, input logic rwr,
                        input logic [15:0] rdata);
    logic push, clr;
    main_io_wr = wr;
    main_io_rd = mrd;
    main_io_addr = addr;
    main_io_din = din;
    snd_rd = srd;
    snd_reply_wr = rwr;
    snd_reply_data = rdata;
    #1;
    check("dout1", {8'h00, dout1}, {8'h00, exp_dout(addr, q1.size(), ov1)});
    check("dout4", {8'h00, dout4}, {8'h00, exp_dout(addr, q4.size(), ov4)});
    @(posedge clk);
    push = wr && (addr == 8'h00);
    clr  = wr && (addr == 8'h0A);
    step_q(1, push, srd, clr, din, q1, ov1, cmd1);
    step_q(4, push, srd, clr, din, q4, ov4, cmd4);
    if (rwr) begin
      m_reply = rdata;
      m_pending = 1'b1;
    end else if (mrd && addr == 8'h09) begin
      m_pending = 1'b0;
    end
    #1;
    main_io_wr = 1'b0;
    main_io_rd = 1'b0;
    snd_rd = 1'b0;
    snd_reply_wr = 1'b0;
    check_outputs();
  endtask

  task automatic push_cmd(input logic [7:0] v);
    access(1'b1, 1'b0, 8'h00, v, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic pop_cmd();
    access(1'b0, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic main_read(input logic [7:0] a);
    access(1'b0, 1'b1, a, 8'h00, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    logic [7:0] addr;
    int r;
    reset = 1'b1;
    main_io_wr = 1'b0;
    main_io_rd = 1'b0;
    main_io_addr = 8'h00;
    main_io_din = 8'h00;
    snd_rd = 1'b0;
    snd_reply_wr = 1'b0;
    snd_reply_data = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    main_read(8'h08);
    check("rst_p09", {8'h00, dout4}, 16'h00FF);
    main_read(8'h09);
    main_read(8'h0A);
    check("rst_irq", {14'd0, sirq4, mirq4}, 16'h0000);

    // Single command
    push_cmd(8'h5A);
    check("single_irq", {15'd0, sirq1}, 16'h0001);
    pop_cmd();
    check("single_cmd", {8'h00, cmd1_o}, 16'h005A);
    check("single_irq0", {15'd0, sirq1}, 16'h0000);

    // Overflow on DEPTH=4, then drain, empty pop and clear
    for (int i = 0; i < 5; i++) push_cmd(8'h10 + 8'(i));
    check("ovf_status4", {8'h00, status4}, 16'h0084);
    for (int i = 0; i < 4; i++) begin
      pop_cmd();
      check("ovf_pop4", {8'h00, cmd4_o}, {8'h00, 8'h10 + 8'(i)});
    end
    check("ovf_irq0", {15'd0, sirq4}, 16'h0000);
    pop_cmd();
    check("empty_pop4", {8'h00, cmd4_o}, 16'h00FF);
    access(1'b1, 1'b0, 8'h0A, 8'h33, 1'b0, 1'b0, 16'h0000);
    check("ovf_clr4", {8'h00, status4}, 16'h0000);

    // Full queue, simultaneous push and pop
    for (int i = 0; i < 4; i++) push_cmd(8'h20 + 8'(i));
    access(1'b1, 1'b0, 8'h00, 8'h24, 1'b1, 1'b0, 16'h0000);
    check("pp_cmd4", {8'h00, cmd4_o}, 16'h0020);
    check("pp_status4", {8'h00, status4}, 16'h0004);
    for (int i = 1; i < 5; i++) pop_cmd();
    check("pp_last4", {8'h00, cmd4_o}, 16'h0024);

    // Empty queue with simultaneous push and pop
    access(1'b1, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0, 16'h0000);
    check("pp_empty_cmd", {8'h00, cmd4_o}, 16'h00FF);
    pop_cmd();

    // Reply handshake
    access(1'b0, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 16'hBEEF);
    check("reply_irq", {15'd0, mirq4}, 16'h0001);
    main_read(8'h08);
    check("reply_lo_keep", {15'd0, mirq4}, 16'h0001);
    main_read(8'h09);
    check("reply_clr", {15'd0, mirq4}, 16'h0000);

    // Reply race: the write wins over the clearing read
    access(1'b0, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 16'h1234);
    access(1'b0, 1'b1, 8'h09, 8'h00, 1'b0, 1'b1, 16'h5678);
    check("race_irq", {15'd0, mirq4}, 16'h0001);
    main_read(8'h08);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: addr = 8'h00;
        5:       addr = 8'h01;
        6:       addr = 8'h08;
        7:       addr = 8'h09;
        8:       addr = 8'h0A;
        default: addr = 8'($urandom);
      endcase
      access($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, addr, 8'($urandom),
             $urandom_range(0, 19) < 7, $urandom_range(0, 19) < 3, 16'($urandom));
    end

    // Asynchronous reset between edges with state loaded
    push_cmd(8'hA5);
    access(1'b0, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 16'hCAFE);
    #2 reset = 1'b1;
    #1;
    model_reset();
    main_io_addr = 8'h09;
    #1;
    check("arst_dout", {8'h00, dout4}, 16'h00FF);
    check("arst_status", {status1, status4}, 16'h0000);
    check("arst_cmd", {cmd1_o, cmd4_o}, 16'h0000);
    check("arst_irq", {12'd0, sirq1, sirq4, mirq1, mirq4}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    main_read(8'h0A);
    pop_cmd();
    check("arst_pop", {8'h00, cmd4_o}, 16'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
